// File: rtl/temp_logger_pkg.sv
// temp_logger_pkg
// Shared parameters for the temperature logger: timestamp field widths,
// the packed log entry layout, the default log depth and the reset values
// of the min/max trackers.
// Ports: none (package).
package temp_logger_pkg;

  localparam int SEC_W   = 6;
  localparam int MIN_W   = 6;
  localparam int HOUR_W  = 5;
  localparam int DAY_W   = 5;
  localparam int MON_W   = 4;
  localparam int STAMP_W = MON_W + DAY_W + HOUR_W + MIN_W + SEC_W;
  localparam int TEMP_W  = 8;
  localparam int ENTRY_W = TEMP_W + STAMP_W;

  localparam int DEPTH_DEFAULT = 16;

  // t_min starts at the top of the range and t_max at the bottom so the
  // first accepted sample always replaces both.
  localparam logic [TEMP_W-1:0] TMIN_RESET = 8'hFF;
  localparam logic [TEMP_W-1:0] TMAX_RESET = 8'h00;

  typedef struct packed {
    logic [TEMP_W-1:0]  temp;
    logic [STAMP_W-1:0] stamp;
  } log_entry_t;

  // Stamp layout, most significant field first: {months,days,hours,minutes,seconds}
  function automatic logic [STAMP_W-1:0] pack_stamp(
    input logic [MON_W-1:0]  mo,
    input logic [DAY_W-1:0]  dy,
    input logic [HOUR_W-1:0] hr,
    input logic [MIN_W-1:0]  mi,
    input logic [SEC_W-1:0]  se
  );
    return {mo, dy, hr, mi, se};
  endfunction

endpackage

// File: rtl/temp_logger_if.sv
// temp_logger_if
// Groups the UART receive strobe and the log read handshake.
//   rx_data/rx_valid/rx_parity_err : byte from the UART receiver
//   rd_req                         : pop request
//   rd_data/rd_stamp/rd_valid      : popped entry, qualified by rd_valid
// master = environment side, slave = logger side.
interface temp_logger_if;
  import temp_logger_pkg::*;

  logic [TEMP_W-1:0]  rx_data;
  logic               rx_valid;
  logic               rx_parity_err;
  logic               rd_req;
  logic [TEMP_W-1:0]  rd_data;
  logic [STAMP_W-1:0] rd_stamp;
  logic               rd_valid;

  modport master (
    output rx_data, rx_valid, rx_parity_err, rd_req,
    input  rd_data, rd_stamp, rd_valid
  );

  modport slave (
    input  rx_data, rx_valid, rx_parity_err, rd_req,
    output rd_data, rd_stamp, rd_valid
  );
endinterface

// File: rtl/temp_log_mem.sv
// temp_log_mem
// DEPTH x 34-bit log storage: one synchronous write port and one registered
// read port. The read register sees the array contents from before a
// same-cycle write, so popping and overwriting the same slot returns the
// old entry.
//   clk, reset      : clock, async active-low reset (read register only)
//   we/waddr/wdata  : write port
//   re/raddr/rdata  : registered read port, rdata holds between reads
module temp_log_mem
  import temp_logger_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEFAULT,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  log_entry_t    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output log_entry_t    rdata
);

  log_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/temp_logger.sv
// temp_logger
// Timestamped temperature log. Accepted UART bytes are stored with the
// current clock time in a ring buffer; parity-errored bytes are counted.
// Tracks min/max of accepted samples and a high-temperature alarm.
//   clk, reset                 : clock, async active-low reset
//   bus (slave)                : rx byte strobe and pop handshake
//   seconds..months            : current time, captured on accept
//   clear                      : synchronous clear of log and statistics
//   count/full/empty/overflow  : occupancy
//   err_count                  : saturating parity error count
//   t_min/t_max/hi_alarm       : sample statistics
module temp_logger
  import temp_logger_pkg::*;
#(
  parameter  int               DEPTH    = DEPTH_DEFAULT,
  parameter  logic [TEMP_W-1:0] HI_LIMIT = 8'd90,
  localparam int               AW       = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  temp_logger_if.slave       bus,
  input  logic [SEC_W-1:0]   seconds,
  input  logic [MIN_W-1:0]   minutes,
  input  logic [HOUR_W-1:0]  hours,
  input  logic [DAY_W-1:0]   days,
  input  logic [MON_W-1:0]   months,
  input  logic               clear,
  output logic [AW:0]        count,
  output logic               full,
  output logic               empty,
  output logic               overflow,
  output logic [7:0]         err_count,
  output logic [TEMP_W-1:0]  t_min,
  output logic [TEMP_W-1:0]  t_max,
  output logic               hi_alarm
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          accept, reject, pop, drop_oldest;
  logic          rd_valid_q;
  log_entry_t    wr_entry, rd_entry;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // clear wins over everything that happens in the same cycle
  assign accept      = bus.rx_valid && !bus.rx_parity_err && !clear;
  assign reject      = bus.rx_valid &&  bus.rx_parity_err && !clear;
  assign pop         = bus.rd_req && !empty && !clear;
  // writing into a full log without a pop overwrites the oldest slot
  assign drop_oldest = accept && full && !pop;

  assign wr_entry = {bus.rx_data, pack_stamp(months, days, hours, minutes, seconds)};

  temp_log_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (accept),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .re    (pop),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  assign bus.rd_data  = rd_entry.temp;
  assign bus.rd_stamp = rd_entry.stamp;
  assign bus.rd_valid = rd_valid_q;

  // Ring pointers, occupancy and the sticky overflow flag. Pointers wrap
  // naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      rd_valid_q <= 1'b0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= pop;
      if (accept)              wr_ptr <= wr_ptr + 1'b1;
      if (pop || drop_oldest)  rd_ptr <= rd_ptr + 1'b1;
      if (accept && !pop && !full) count <= count + 1'b1;
      else if (pop && !accept)     count <= count - 1'b1;
      if (drop_oldest) overflow <= 1'b1;
    end
  end

  // Sample statistics: parity error counter, extremes and the alarm.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count <= '0;
      t_min     <= TMIN_RESET;
      t_max     <= TMAX_RESET;
      hi_alarm  <= 1'b0;
    end else if (clear) begin
      err_count <= '0;
      t_min     <= TMIN_RESET;
      t_max     <= TMAX_RESET;
      hi_alarm  <= 1'b0;
    end else begin
      if (reject && err_count != 8'hFF) err_count <= err_count + 1'b1;
      if (accept) begin
        if (bus.rx_data < t_min) t_min <= bus.rx_data;
        if (bus.rx_data > t_max) t_max <= bus.rx_data;
        hi_alarm <= (bus.rx_data > HI_LIMIT);
      end
    end
  end

endmodule

// File: tb/tb_temp_logger.sv
// tb_temp_logger
// Self-checking bench for temp_logger: a directed vector table, a few
// hand-written multi-cycle sequences and a randomized phase, all compared
// against a queue-based reference model of the log.
module tb_temp_logger;
  import temp_logger_pkg::*;

  localparam int DEPTH = 16;

  logic               clk;
  logic               reset;
  logic [SEC_W-1:0]   seconds;
  logic [MIN_W-1:0]   minutes;
  logic [HOUR_W-1:0]  hours;
  logic [DAY_W-1:0]   days;
  logic [MON_W-1:0]   months;
  logic               clear;
  logic [4:0]         count;
  logic               full, empty, overflow, hi_alarm;
  logic [7:0]         err_count, t_min, t_max;

  temp_logger_if bus();

  temp_logger #(.DEPTH(DEPTH), .HI_LIMIT(8'd90)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .seconds   (seconds),
    .minutes   (minutes),
    .hours     (hours),
    .days      (days),
    .months    (months),
    .clear     (clear),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .err_count (err_count),
    .t_min     (t_min),
    .t_max     (t_max),
    .hi_alarm  (hi_alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  typedef struct {
    logic [7:0]  temp;
    logic [25:0] stamp;
  } model_entry_t;

  model_entry_t model_q[$];
  logic         m_ovf;
  int           m_err;
  logic [7:0]   m_tmin, m_tmax;
  logic         m_alarm;
  logic         m_rv;
  logic [7:0]   m_rd_data;
  logic [25:0]  m_rd_stamp;

  int assert_count = 0;
  int fail_count   = 0;

  typedef struct {
    logic       rxv;
    logic       perr;
    logic [7:0] data;
    logic       rdreq;
    logic       clr;
    int         exp_count;
    logic       exp_rv;
    logic [7:0] exp_data;
    logic [7:0] exp_tmin;
    logic [7:0] exp_tmax;
    logic       exp_alarm;
    logic [7:0] exp_err;
  } vec_t;

  vec_t vecs[14];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    m_ovf      = 1'b0;
    m_err      = 0;
    m_tmin     = 8'hFF;
    m_tmax     = 8'h00;
    m_alarm    = 1'b0;
    m_rv       = 1'b0;
    m_rd_data  = 8'h00;
    m_rd_stamp = 26'h0;
  endtask

  task automatic check_against_model();
    checkOutput("count",     32'(count),     32'(model_q.size()));
    checkOutput("full",      32'(full),      32'(model_q.size() == DEPTH));
    checkOutput("empty",     32'(empty),     32'(model_q.size() == 0));
    checkOutput("overflow",  32'(overflow),  32'(m_ovf));
    checkOutput("err_count", 32'(err_count), 32'(m_err));
    checkOutput("t_min",     32'(t_min),     32'(m_tmin));
    checkOutput("t_max",     32'(t_max),     32'(m_tmax));
    checkOutput("hi_alarm",  32'(hi_alarm),  32'(m_alarm));
    checkOutput("rd_valid",  32'(bus.rd_valid), 32'(m_rv));
    checkOutput("rd_data",   32'(bus.rd_data),  32'(m_rd_data));
    checkOutput("rd_stamp",  32'(bus.rd_stamp), 32'(m_rd_stamp));
  endtask

  // Drives one cycle of inputs (called at a falling edge), advances the
  // model by the same cycle, then checks all outputs just after the edge.
  task automatic applyStimulus(input logic rxv, input logic perr, input logic [7:0] data,
                               input logic rdreq, input logic clr);
    model_entry_t e;
    bus.rx_valid      = rxv;
    bus.rx_parity_err = perr;
    bus.rx_data       = data;
    bus.rd_req        = rdreq;
    clear             = clr;
    seconds = 6'($urandom_range(0, 59));
    minutes = 6'($urandom_range(0, 59));
    hours   = 5'($urandom_range(0, 23));
    days    = 5'($urandom_range(1, 31));
    months  = 4'($urandom_range(1, 12));

    m_rv = 1'b0;
    if (clr) begin
      model_q.delete();
      m_ovf   = 1'b0;
      m_err   = 0;
      m_tmin  = 8'hFF;
      m_tmax  = 8'h00;
      m_alarm = 1'b0;
    end else begin
      if (rdreq && model_q.size() > 0) begin
        e          = model_q.pop_front();
        m_rv       = 1'b1;
        m_rd_data  = e.temp;
        m_rd_stamp = e.stamp;
      end
      if (rxv && !perr) begin
        e.temp  = data;
        e.stamp = {months, days, hours, minutes, seconds};
        model_q.push_back(e);
        if (model_q.size() > DEPTH) begin
          void'(model_q.pop_front());
          m_ovf = 1'b1;
        end
        if (data < m_tmin) m_tmin = data;
        if (data > m_tmax) m_tmax = data;
        m_alarm = (data > 8'd90);
      end
      if (rxv && perr && m_err < 255) m_err++;
    end

    @(posedge clk);
    #1;
    check_against_model();
    bus.rx_valid      = 1'b0;
    bus.rx_parity_err = 1'b0;
    bus.rd_req        = 1'b0;
    clear             = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    check_against_model();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    clear = 1'b0;
    bus.rx_valid = 1'b0; bus.rx_parity_err = 1'b0; bus.rx_data = 8'h00; bus.rd_req = 1'b0;
    seconds = '0; minutes = '0; hours = '0; days = '0; months = '0;

    //            rxv perr data rdq clr  cnt rv  data tmin tmax alm err
    vecs[0]  = '{1, 0, 20,  0, 0,  1, 0, 0,   20,  20,  0, 0};
    vecs[1]  = '{1, 0, 35,  0, 0,  2, 0, 0,   20,  35,  0, 0};
    vecs[2]  = '{1, 0, 28,  0, 0,  3, 0, 0,   20,  35,  0, 0};
    vecs[3]  = '{0, 0, 0,   1, 0,  2, 1, 20,  20,  35,  0, 0};
    vecs[4]  = '{0, 0, 0,   1, 0,  1, 1, 35,  20,  35,  0, 0};
    vecs[5]  = '{0, 0, 0,   1, 0,  0, 1, 28,  20,  35,  0, 0};
    vecs[6]  = '{0, 0, 0,   0, 0,  0, 0, 28,  20,  35,  0, 0};
    vecs[7]  = '{0, 0, 0,   1, 0,  0, 0, 28,  20,  35,  0, 0};
    vecs[8]  = '{1, 0, 95,  0, 0,  1, 0, 28,  20,  95,  1, 0};
    vecs[9]  = '{1, 0, 40,  0, 0,  2, 0, 28,  20,  95,  0, 0};
    vecs[10] = '{1, 1, 10,  0, 0,  2, 0, 28,  20,  95,  0, 1};
    vecs[11] = '{1, 0, 50,  1, 0,  2, 1, 95,  20,  95,  0, 1};
    vecs[12] = '{1, 0, 60,  1, 1,  0, 0, 95,  255, 0,   0, 0};
    vecs[13] = '{1, 0, 7,   1, 0,  1, 0, 95,  7,   7,   0, 0};

    @(negedge clk);
    do_reset();

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].rxv, vecs[i].perr, vecs[i].data, vecs[i].rdreq, vecs[i].clr);
      checkOutput($sformatf("vec%0d_count", i),  32'(count),        32'(vecs[i].exp_count));
      checkOutput($sformatf("vec%0d_rv", i),     32'(bus.rd_valid), 32'(vecs[i].exp_rv));
      checkOutput($sformatf("vec%0d_data", i),   32'(bus.rd_data),  32'(vecs[i].exp_data));
      checkOutput($sformatf("vec%0d_tmin", i),   32'(t_min),        32'(vecs[i].exp_tmin));
      checkOutput($sformatf("vec%0d_tmax", i),   32'(t_max),        32'(vecs[i].exp_tmax));
      checkOutput($sformatf("vec%0d_alarm", i),  32'(hi_alarm),     32'(vecs[i].exp_alarm));
      checkOutput($sformatf("vec%0d_err", i),    32'(err_count),    32'(vecs[i].exp_err));
    end

    // Overwrite when full: 18 writes into a 16-deep log
    do_reset();
    for (int i = 1; i <= DEPTH + 2; i++) applyStimulus(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
    checkOutput("ovf_flag",  32'(overflow), 32'd1);
    checkOutput("ovf_count", 32'(count),    32'd16);
    checkOutput("ovf_full",  32'(full),     32'd1);
    for (int i = 3; i <= DEPTH + 2; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("ovf_pop_data",  32'(bus.rd_data),  32'(i));
      checkOutput("ovf_pop_valid", 32'(bus.rd_valid), 32'd1);
    end

    // 300 parity-errored bytes saturate the counter and touch nothing else
    for (int i = 0; i < 300; i++) applyStimulus(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0);
    checkOutput("perr_count", 32'(err_count), 32'd255);
    checkOutput("perr_cnt0",  32'(count),     32'd0);
    checkOutput("perr_tmin",  32'(t_min),     32'd1);
    checkOutput("perr_tmax",  32'(t_max),     32'd18);

    // Simultaneous accept and pop while full
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 8'(100 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'd200, 1'b1, 1'b0);
    checkOutput("fullrw_count", 32'(count),        32'd16);
    checkOutput("fullrw_ovf",   32'(overflow),     32'd0);
    checkOutput("fullrw_data",  32'(bus.rd_data),  32'd100);
    checkOutput("fullrw_valid", 32'(bus.rd_valid), 32'd1);

    // Reset arriving between rd_req and the next edge cancels the pop
    bus.rd_req = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_against_model();
    @(posedge clk);
    #1;
    checkOutput("rstpop_valid", 32'(bus.rd_valid), 32'd0);
    check_against_model();
    bus.rd_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      int r;
      logic rxv, perr, rdq, clr;
      r    = $urandom_range(0, 99);
      rxv  = (r < 60);
      perr = rxv && ($urandom_range(0, 9) == 0);
      rdq  = ($urandom_range(0, 99) < 40);
      clr  = ($urandom_range(0, 99) < 2);
      applyStimulus(rxv, perr, 8'($urandom), rdq, clr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/temp_logger.md
TEMP_LOGGER -- requirements
Module: temp_logger

Interface
REQ-001 SHALL have parameter DEPTH, default 16, giving the number of log entries (power of two, 4..64).
REQ-002 SHALL have parameter HI_LIMIT, default 8'd90, giving the high-temperature alarm threshold in raw units.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rx_data  input  8  received temperature byte from the UART receiver.
REQ-006 SHALL have port rx_valid  input  1  one-cycle strobe marking rx_data and rx_parity_err valid.
REQ-007 SHALL have port rx_parity_err  input  1  parity error flag for the current byte.
REQ-008 SHALL have ports seconds(6), minutes(6), hours(5), days(5), months(4)  input  current digital-clock time.
REQ-009 SHALL have port clear  input  1  synchronous clear of the log and statistics.
REQ-010 SHALL have port rd_req  input  1  request to pop the oldest entry.
REQ-011 SHALL have port rd_data  output  8  popped temperature.
REQ-012 SHALL have port rd_stamp  output  26  popped timestamp {months,days,hours,minutes,seconds}.
REQ-013 SHALL have port rd_valid  output  1  one-cycle strobe qualifying rd_data and rd_stamp.
REQ-014 SHALL have port count  output  clog2(DEPTH)+1  number of stored entries.
REQ-015 SHALL have ports full and empty  output  1 each  occupancy flags.
REQ-016 SHALL have port overflow  output  1  sticky flag: an entry was overwritten.
REQ-017 SHALL have port err_count  output  8  saturating count of parity-errored bytes.
REQ-018 SHALL have ports t_min and t_max  output  8 each  extremes of the accepted samples.
REQ-019 SHALL have port hi_alarm  output  1  high while the last accepted sample exceeds HI_LIMIT.

Function
REQ-020 SHALL accept a sample when rx_valid=1 and rx_parity_err=0, storing rx_data plus the timestamp inputs sampled in the same cycle.
REQ-021 SHALL discard a byte when rx_valid=1 and rx_parity_err=1, incrementing err_count and saturating at 255.
REQ-022 SHALL organise storage as a ring buffer with write and read pointers that wrap modulo DEPTH.
REQ-023 On an accept while full with no pop, SHALL overwrite the oldest entry, advance both pointers, hold count=DEPTH and set overflow.
REQ-024 On rd_req with count>0, SHALL assert rd_valid exactly one cycle later with the oldest entry, and SHALL decrement count.
REQ-025 SHALL ignore rd_req with count=0: no rd_valid, no pointer change.
REQ-026 On a simultaneous accept and pop while full, SHALL pop the oldest entry, store the new one, leave count unchanged and not set overflow.
REQ-027 On a simultaneous accept and pop while empty, SHALL store the entry, produce no rd_valid and provide no bypass, giving count=1.
REQ-028 SHALL update t_min and t_max on every accepted sample using unsigned compares.
REQ-029 SHALL register hi_alarm as (sample > HI_LIMIT) on each accept, and hold it until the next accept.
REQ-030 SHALL drive full=(count==DEPTH) and empty=(count==0) combinationally from count.
REQ-031 On clear=1, SHALL zero the pointers, count, overflow, err_count and hi_alarm, set t_min=8'hFF and t_max=8'h00, and drop any same-cycle accept or pop.
REQ-032 SHALL hold rd_data and rd_stamp stable between pops.

Reset
REQ-033 With reset low, SHALL immediately set count=0, pointers=0, rd_valid=0, overflow=0, err_count=0, hi_alarm=0, t_min=8'hFF, t_max=8'h00, rd_data=0 and rd_stamp=0.
REQ-034 SHALL lose any pending pop on reset mid-operation; stored array contents need not be cleared.
REQ-035 SHALL accept samples from the first rising edge after reset deasserts.

Structure
REQ-036 SHALL take the timestamp field widths, the 26-bit stamp width, the DEPTH default and the t_min/t_max reset constants from the shared parameters file.
REQ-037 SHALL implement storage in one sub-module, temp_log_mem: a DEPTH x 34-bit array with one synchronous write port and one registered read port.

Verification
REQ-038 Reset, write 3 samples (20, 35, 28), then pop 3 -> rd_data 20, 35, 28 in order; count 0; t_min=20; t_max=35.
REQ-039 Write DEPTH+2 samples (values 1..18) with no pops -> overflow=1, count=16; pops return 3..18.
REQ-040 Send 300 bytes with rx_parity_err=1 -> err_count=255, count=0, t_min/t_max unchanged.
REQ-041 When full, accept and pop in the same cycle -> count stays 16, overflow=0, popped value is the oldest.
REQ-042 Accept 95, then 40, with HI_LIMIT=90 -> hi_alarm goes 1, then 0; t_max=95.
REQ-043 Assert reset low between rd_req and the next edge -> no rd_valid; all outputs take the REQ-033 values.
